// File: rtl/apb_slave_param.sv
// Parametrised APB slave register bank with configurable width, depth and wait states.
// Optional byte-strobe writes are enabled by defining APB_SLV_PSTRB_EN.
module apb_slave_param #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 4,
  parameter int unsigned       DEPTH       = 16,
  parameter int unsigned       WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic [ADDR_W-1:0]   paddr_i,
  input  logic                pwrite_i,
  input  logic [DATA_W-1:0]   pwdata_i,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb_i,
`endif
  output logic [DATA_W-1:0]   prdata_o,
  output logic                pready_o,
  output logic                pslverr_o
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {StIdle, StAccess} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]       strb_q, strb_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [NB-1:0]       strb_in;
  logic [IdxW-1:0]     idx;
  logic                in_range;
  logic                ready;
  logic                commit;

`ifdef APB_SLV_PSTRB_EN
  assign strb_in = pstrb_i;
`else
  assign strb_in = '1;
`endif

  // Range check at ADDR_W+1 bits so DEPTH == 2**ADDR_W never flags an error.
  assign in_range = {1'b0, addr_q} < (ADDR_W + 1)'(DEPTH);
  assign idx      = addr_q[IdxW-1:0];
  assign ready    = (state_q == StAccess) && (cnt_q == 4'd0);

  assign pready_o  = ready;
  assign pslverr_o = ready && !in_range;
  assign prdata_o  = (ready && !wr_q && in_range) ? mem_q[idx] : '0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (psel_i && !penable_i) begin
          state_d = StAccess;
          addr_d  = paddr_i;
          wr_d    = pwrite_i;
          wdata_d = pwdata_i;
          strb_d  = strb_in;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      StAccess: begin
        if (!psel_i) begin
          state_d = StIdle;
        end else if (penable_i) begin
          if (!ready) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = StIdle;
            commit  = wr_q && in_range;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else if (commit) begin
      for (int k = 0; k < int'(NB); k++) begin
        if (strb_q[k]) begin
          mem_q[idx][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: doc/apb_slave_param.md
Name: apb_slave_param

Overview:
Parametrised APB slave register bank that succeeds the fixed 16x32 APB slave. Data width, address width, depth and wait-state count are all configurable. Out-of-range accesses return PSLVERR. Protocol aborts are handled cleanly. Sits on the peripheral APB bus behind the bridge and serves as a generic configuration/scratch register file.

Parameters:
DATA_W, 32, data bus width in bits; multiple of 8, 8..64.
ADDR_W, 4, word-address width of paddr_i.
DEPTH, 16, implemented words; 1 <= DEPTH <= 2**ADDR_W.
WAIT_CYCLES, 0, wait states inserted in the access phase (0..15).
RESET_VAL, 0, reset value of every memory word (DATA_W bits).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
psel_i  input  1  APB select
penable_i  input  1  APB enable (access phase)
paddr_i  input  ADDR_W  word address
pwrite_i  input  1  1=write, 0=read
pwdata_i  input  DATA_W  write data
prdata_o  output  DATA_W  read data, valid while pready_o=1 on a read
pready_o  output  1  transfer complete
pslverr_o  output  1  error response, valid while pready_o=1

Behaviour:
- One clock domain (clk). Reset rst is asynchronous and active-high.
- While rst=1: state=IDLE; all memory words=RESET_VAL; pready_o=0; pslverr_o=0; prdata_o=0.
- Reset asserted mid-transfer: the transfer is dropped immediately and no write occurs.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On a clock edge with psel_i=1 and penable_i=0 (setup phase), latch paddr_i, pwrite_i and pwdata_i into addr_q, wr_q and wdata_q.
  - Load wait counter cnt=WAIT_CYCLES, then go to ACCESS.
  - penable_i=1 seen in IDLE is ignored.
- ACCESS:
  - pready_o=(cnt==0). This is a Moore output derived from registers; there is no combinational path from inputs.
  - If psel_i=1, penable_i=1 and cnt!=0: cnt decrements.
  - If psel_i=1, penable_i=1 and pready_o=1: the transfer completes at this edge and the FSM returns to IDLE.
  - If psel_i=0 at an edge while in ACCESS: abort. Return to IDLE, no write, no response.
- Address, write and data changes during ACCESS are ignored; the latched values are used.
- Zero-wait timing (WAIT_CYCLES=0): pready_o=1 in the first access cycle. In general pready_o is high in access cycle WAIT_CYCLES+1.
- Write commit:
  - mem[addr_q] <= wdata_q on the completing edge, only when wr_q=1 and addr_q<DEPTH.
  - A write with addr_q>=DEPTH is discarded.
- Read data:
  - When pready_o=1 and wr_q=0: prdata_o=mem[addr_q] if addr_q<DEPTH, else 0.
  - prdata_o=0 in all other cycles.
- pslverr_o=pready_o && (addr_q>=DEPTH); 0 otherwise.
- Back-to-back transfers: the completing edge returns the FSM to IDLE. The next setup phase, presented in the following cycle, is captured with no bubble.
- Read-after-write to the same address in consecutive transfers returns the new data.
- Width rules: addr_q is compared against DEPTH at ADDR_W+1 bits. When DEPTH=2**ADDR_W, pslverr_o is never asserted.

Optional Feature:
APB_SLV_PSTRB_EN:
- Defined: adds port pstrb_i (input, DATA_W/8 bits), latched in the setup phase with the other request fields. On write commit, byte lane k is updated only if pstrb_q[k]=1. pstrb_i is ignored on reads. A write with all strobes 0 completes normally and changes nothing.
- Undefined: the port is absent and every write updates the full word.

Test Plan:
- Reset values (WAIT_CYCLES=0): assert rst asynchronously between clock edges -> prdata_o=0, pready_o=0, pslverr_o=0 immediately; then read all 16 addresses -> each returns RESET_VAL with pslverr_o=0.
- Write/read with waits (WAIT_CYCLES=2): write 32'hDEADBEEF to address 5 -> pready_o rises in the 3rd access cycle. Read address 5 -> prdata_o=32'hDEADBEEF. Read address 4 -> prdata_o=0.
- Out of range (DEPTH=12): write 32'h12345678 to address 13 -> pready_o=1 with pslverr_o=1 and no memory change. Read address 13 -> prdata_o=0 with pslverr_o=1.
- Abort (WAIT_CYCLES=3): write 32'hA5A5A5A5 to address 2, drop psel_i in the 2nd access cycle -> no pready_o pulse and mem[2] unchanged. The next normal read of address 2 returns its old value.
- Back-to-back: write address 1 = 32'h0000_0011, immediately followed by a read of address 1 with no idle cycle -> read returns 32'h0000_0011. With WAIT_CYCLES=0, each transfer takes 2 cycles.
- With APB_SLV_PSTRB_EN: write 32'hFFFFFFFF, then write 32'h00000000 with pstrb_i=4'b0101 -> read returns 32'hFF00FF00.
